pinsert: RTL

- Transmit-side framer for the byte-stream sync protocol; counterpart to the pattern detector on the receive side.
- On a start request it emits the 32-bit sync PATTERN (MSB byte first), then exactly PAYLOAD_LEN payload bytes taken from an upstream valid/ready source.
- Output is a registered byte lane with valid/ready, intended to feed the serializer/link, whose far end runs the detector.

---
 rtl/pdetect_pkg.sv | 27 ++
 rtl/pinsert.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pdetect_pkg.sv
// Shared definitions for the sync-pattern detector and inserter:
// default sync word, inserter state encoding and a pattern byte selector.
package pdetect_pkg;

  localparam logic [31:0] SYNC_PATTERN = 32'h0A0B0C0D;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PAYLOAD,
    CSUM,
    DONE
  } pinsert_state_e;

  // Byte idx of the sync word, MSB byte first on the wire.
  function automatic logic [7:0] pattern_byte(input logic [31:0] pat, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = pat[31:24];
      2'd1:    b = pat[23:16];
      2'd2:    b = pat[15:8];
      default: b = pat[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pinsert.sv
// Transmit framer: sync word, then PAYLOAD_LEN payload bytes on a registered valid/ready lane.
// Define PINSERT_CHECKSUM_EN to append an XOR checksum byte that carries o_eof.
//
// state   | meaning
// IDLE    | no frame, waiting for i_start
// SYNC    | loading the four sync pattern bytes
// PAYLOAD | passing upstream bytes through, bubbles allowed
// CSUM    | loading the XOR checksum byte (PINSERT_CHECKSUM_EN only)
// DONE    | EOF byte held until downstream accepts it
module pinsert
  import pdetect_pkg::*;
#(
  parameter logic [31:0] PATTERN     = SYNC_PATTERN,
  parameter int unsigned PAYLOAD_LEN = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_busy,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_sof,
  output logic       o_eof
);

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

  pinsert_state_e state, state_nxt;
  logic [7:0] count, count_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt, sof_nxt, eof_nxt, busy_nxt;
  logic       advance;
`ifdef PINSERT_CHECKSUM_EN
  logic [7:0] csum, csum_nxt;
`endif

  // The output register may load whenever it is empty or being drained.
  assign advance = !o_valid || i_ready;
  assign o_ready = (state == PAYLOAD) && advance;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    data_nxt  = o_data;
    valid_nxt = o_valid;
    sof_nxt   = o_sof;
    eof_nxt   = o_eof;
    busy_nxt  = o_busy;
`ifdef PINSERT_CHECKSUM_EN
    csum_nxt  = csum;
`endif
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        sof_nxt   = 1'b0;
        eof_nxt   = 1'b0;
        if (i_start) begin
          state_nxt = SYNC;
          count_nxt = 8'd0;
          busy_nxt  = 1'b1;
`ifdef PINSERT_CHECKSUM_EN
          csum_nxt  = 8'd0;
`endif
        end
      end
      SYNC: begin
        if (advance) begin
          data_nxt  = pattern_byte(PATTERN, count[1:0]);
          valid_nxt = 1'b1;
          sof_nxt   = (count == 8'd0);
          eof_nxt   = 1'b0;
          if (count == 8'd3) begin
            state_nxt = PAYLOAD;
            count_nxt = 8'd0;
          end else begin
            count_nxt = count + 8'd1;
          end
        end
      end
      PAYLOAD: begin
        if (advance) begin
          sof_nxt = 1'b0;
          eof_nxt = 1'b0;
          if (i_valid) begin
            data_nxt  = i_data;
            valid_nxt = 1'b1;
            count_nxt = count + 8'd1;
`ifdef PINSERT_CHECKSUM_EN
            csum_nxt  = csum ^ i_data;
            if (count == LAST_IDX) state_nxt = CSUM;
`else
            if (count == LAST_IDX) begin
              eof_nxt   = 1'b1;
              state_nxt = DONE;
            end
`endif
          end else begin
            valid_nxt = 1'b0;
          end
        end
      end
`ifdef PINSERT_CHECKSUM_EN
      CSUM: begin
        if (advance) begin
          data_nxt  = csum;
          valid_nxt = 1'b1;
          sof_nxt   = 1'b0;
          eof_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        if (i_ready) begin
          valid_nxt = 1'b0;
          eof_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      count   <= 8'd0;
      o_data  <= 8'h00;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
      o_busy  <= 1'b0;
`ifdef PINSERT_CHECKSUM_EN
      csum    <= 8'd0;
`endif
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      o_data  <= data_nxt;
      o_valid <= valid_nxt;
      o_sof   <= sof_nxt;
      o_eof   <= eof_nxt;
      o_busy  <= busy_nxt;
`ifdef PINSERT_CHECKSUM_EN
      csum    <= csum_nxt;
`endif
    end
  end

endmodule
